// File: rtl/bcd_hour_display.sv
// bcd_hour_display: two-digit multiplexed 7-segment driver for the hour counter.
// The BCD pair is sampled once per refresh frame into shadow registers and
// scanned out ones-then-tens, with leading-zero blanking and time-set blink.
module bcd_hour_display #(
    parameter int REFRESH_DIV    = 50000,
    parameter int BLINK_FRAMES   = 64,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int DIG_ACTIVE_LOW = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] in_q1,
    input  logic [3:0] in_q2,
    input  logic       blank_lz,
    input  logic       blink_en,
    output logic [6:0] seg,
    output logic [1:0] dig,
    output logic       frame_tick
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [1:0] DIG_OFF = (DIG_ACTIVE_LOW != 0) ? 2'b11 : 2'b00;

    typedef enum logic {
        ONES = 1'b0,
        TENS = 1'b1
    } state_t;

    state_t         state;
    logic [PW-1:0]  pre_cnt;
    logic [FW-1:0]  frame_cnt;
    logic           blink_phase;
    logic [3:0]     sh_q1;
    logic [3:0]     sh_q2;
    logic           slot_tick;
    logic           frame_boundary;
    logic [3:0]     cur_digit;
    logic [6:0]     seg_on;
    logic [6:0]     seg_next;
    logic [1:0]     dig_next;

    // Active-high segment code {g,f,e,d,c,b,a}; non-BCD codes show a dash.
    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h3F;
            4'd1:    decode = 7'h06;
            4'd2:    decode = 7'h5B;
            4'd3:    decode = 7'h4F;
            4'd4:    decode = 7'h66;
            4'd5:    decode = 7'h6D;
            4'd6:    decode = 7'h7D;
            4'd7:    decode = 7'h07;
            4'd8:    decode = 7'h7F;
            4'd9:    decode = 7'h6F;
            default: decode = 7'h40;
        endcase
    endfunction

    assign slot_tick      = (pre_cnt == PW'(REFRESH_DIV - 1));
    assign frame_boundary = slot_tick && (state == TENS);

    // Prescaler: one slot_tick every REFRESH_DIV cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (slot_tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 1'b1;
        end
    end

    // Next segment/digit pattern for the slot currently being scanned.
    // Blink blanking keys on blink_phase alone: the phase is forced to 0 the
    // edge after blink_en drops, so segments relight one edge after that.
    always_comb begin
        cur_digit = (state == TENS) ? sh_q1 : sh_q2;
        seg_on    = decode(cur_digit);
        if (blink_phase) begin
            seg_on = '0;
        end else if ((state == TENS) && blank_lz && (sh_q1 == 4'd0)) begin
            seg_on = '0;
        end
        seg_next = (SEG_ACTIVE_LOW != 0) ? ~seg_on : seg_on;
        dig_next = (state == TENS) ? 2'b10 : 2'b01;
        if (DIG_ACTIVE_LOW != 0) begin
            dig_next = ~dig_next;
        end
    end

    // Scan FSM, frame-boundary shadow capture, blink timing and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ONES;
            sh_q1       <= '0;
            sh_q2       <= '0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
            seg         <= SEG_OFF;
            dig         <= DIG_OFF;
            frame_tick  <= 1'b0;
        end else begin
            seg        <= seg_next;
            dig        <= dig_next;
            frame_tick <= frame_boundary;
            if (slot_tick) begin
                state <= (state == ONES) ? TENS : ONES;
            end
            if (frame_boundary) begin
                sh_q1 <= in_q1;
                sh_q2 <= in_q2;
            end
            if (!blink_en) begin
                frame_cnt   <= '0;
                blink_phase <= 1'b0;
            end else if (frame_boundary) begin
                if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
                    frame_cnt   <= '0;
                    blink_phase <= ~blink_phase;
                end else begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_hour_display.sv
// tb_bcd_hour_display: directed vectors for the multiplexed hour display,
// REFRESH_DIV=4, BLINK_FRAMES=2, active-low segments and digit enables.
module tb_bcd_hour_display;

    logic       clk;
    logic       rst_n;
    logic [3:0] in_q1;
    logic [3:0] in_q2;
    logic       blank_lz;
    logic       blink_en;
    logic [6:0] seg;
    logic [1:0] dig;
    logic       frame_tick;

    int errors;
    int checks;
    int e;

    bcd_hour_display #(
        .REFRESH_DIV   (4),
        .BLINK_FRAMES  (2),
        .SEG_ACTIVE_LOW(1),
        .DIG_ACTIVE_LOW(1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_q1     (in_q1),
        .in_q2     (in_q2),
        .blank_lz  (blank_lz),
        .blink_en  (blink_en),
        .seg       (seg),
        .dig       (dig),
        .frame_tick(frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @edge %0d: got %h expected %h", tag, e, got, exp);
        end
    endtask

    // Apply reset with the given inputs, check reset values, release before edge 1.
    task automatic start(input logic [3:0] q1, input logic [3:0] q2,
                         input logic lz, input logic ben);
        rst_n    = 1'b0;
        in_q1    = q1;
        in_q2    = q2;
        blank_lz = lz;
        blink_en = ben;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_seg", {1'b0, seg}, 8'h7F);
        chk("rst_dig", {6'd0, dig}, 8'h03);
        chk("rst_ft", {7'd0, frame_tick}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        e = 0;
    endtask

    task automatic step_to(input int n);
        while (e < n) begin
            @(posedge clk);
            #1;
            e++;
        end
    endtask

    task automatic chk_out(input string tag, input logic [6:0] s, input logic [1:0] d);
        chk({tag, "_seg"}, {1'b0, seg}, {1'b0, s});
        chk({tag, "_dig"}, {6'd0, dig}, {6'd0, d});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        errors   = 0;
        checks   = 0;
        e        = 0;
        rst_n    = 1'b0;
        in_q1    = 4'd0;
        in_q2    = 4'd0;
        blank_lz = 1'b0;
        blink_en = 1'b0;

        // Normal display of 23
        start(4'd2, 4'd3, 1'b0, 1'b0);
        step_to(1);
        chk_out("e1", 7'h40, 2'b10);
        chk("ft_e1", {7'd0, frame_tick}, 8'h00);
        step_to(4);
        chk_out("e4", 7'h40, 2'b10);
        step_to(5);
        chk_out("e5", 7'h40, 2'b01);
        step_to(7);
        chk("ft_e7", {7'd0, frame_tick}, 8'h00);
        step_to(8);
        chk("ft_e8", {7'd0, frame_tick}, 8'h01);
        for (int k = 9; k <= 24; k++) begin
            step_to(k);
            if (k == 9 || k == 17)
                chk("ft_after", {7'd0, frame_tick}, 8'h00);
            if (k == 16)
                chk("ft_e16", {7'd0, frame_tick}, 8'h01);
            if ((((k - 1) / 4) % 2) == 0)
                chk_out("n23_ones", 7'h30, 2'b10);
            else
                chk_out("n23_tens", 7'h24, 2'b01);
        end

        // Tear-free update 09 -> 10 in the middle of the tens slot
        start(4'd0, 4'd9, 1'b0, 1'b0);
        step_to(12);
        chk_out("tf_e12", 7'h10, 2'b10);
        step_to(13);
        in_q1 = 4'd1;
        in_q2 = 4'd0;
        chk_out("tf_e13", 7'h40, 2'b01);
        step_to(16);
        chk_out("tf_e16", 7'h40, 2'b01);
        step_to(17);
        chk_out("tf_e17", 7'h40, 2'b10);
        step_to(21);
        chk_out("tf_e21", 7'h79, 2'b01);

        // Reset mid-frame: outputs go off immediately, shadows restart at 0
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_out("mid_rst", 7'h7F, 2'b11);
        @(negedge clk);
        rst_n = 1'b1;
        e = 0;
        step_to(1);
        chk_out("mr_e1", 7'h40, 2'b10);
        step_to(5);
        chk_out("mr_e5", 7'h40, 2'b01);

        // Leading-zero blanking on 05
        start(4'd0, 4'd5, 1'b1, 1'b0);
        step_to(9);
        chk_out("lz_ones", 7'h12, 2'b10);
        step_to(13);
        chk_out("lz_tens", 7'h7F, 2'b01);
        blank_lz = 1'b0;
        step_to(14);
        chk_out("nolz_tens", 7'h40, 2'b01);

        // Non-BCD codes show a dash
        start(4'hA, 4'hF, 1'b0, 1'b0);
        step_to(9);
        chk_out("inv_ones", 7'h3F, 2'b10);
        step_to(13);
        chk_out("inv_tens", 7'h3F, 2'b01);

        // Blink held on from reset
        start(4'd2, 4'd3, 1'b0, 1'b1);
        step_to(16);
        chk_out("bl_e16", 7'h24, 2'b01);
        for (int k = 17; k <= 32; k++) begin
            step_to(k);
            if ((((k - 1) / 4) % 2) == 0)
                chk_out("bl_off_ones", 7'h7F, 2'b10);
            else
                chk_out("bl_off_tens", 7'h7F, 2'b01);
        end
        step_to(33);
        chk_out("bl_e33", 7'h30, 2'b10);

        // Blink dropped during the off phase
        start(4'd2, 4'd3, 1'b0, 1'b1);
        step_to(20);
        chk_out("bd_e20", 7'h7F, 2'b10);
        blink_en = 1'b0;
        step_to(21);
        chk_out("bd_e21", 7'h7F, 2'b01);
        step_to(22);
        chk_out("bd_e22", 7'h24, 2'b01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_hour_display.md
# bcd_hour_display

Two-digit multiplexed 7-segment driver for the BCD hour counters: tens and ones digit codes in, time-multiplexed segment and digit-enable lines out.
- Samples the BCD pair once per refresh frame into shadow registers, so a digit pair never tears mid-frame.
- Decodes each digit, with optional leading-zero blanking and blink for time-set mode.
- Sits between the 0–23 hour counter and the board's common-anode/cathode display pins.

## Interface
- REFRESH_DIV, 50000 — clk cycles per digit slot; legal range ≥ 2.
- BLINK_FRAMES, 64 — refresh frames per blink half-period; legal range ≥ 1.
- SEG_ACTIVE_LOW, 1 — 1: seg lines driven low to light.
- DIG_ACTIVE_LOW, 1 — 1: dig lines driven low to enable.
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_q1  input  4  BCD tens digit from hour counter.
- in_q2  input  4  BCD ones digit from hour counter.
- blank_lz  input  1  1: tens digit dark when its shadow value is 0.
- blink_en  input  1  1: all segments dark during the blink-off phase.
- seg  output  7  segments {g,f,e,d,c,b,a}, polarity per SEG_ACTIVE_LOW.
- dig  output  2  dig[0] = ones enable, dig[1] = tens enable, polarity per DIG_ACTIVE_LOW.
- frame_tick  output  1  one-cycle pulse at every shadow capture.

## Operation
- **Prescaler:** counts 0..REFRESH_DIV-1 and wraps. slot_tick = (count == REFRESH_DIV-1).
- **Scan FSM:** two states, ONES and TENS; reset state is ONES.
  - On slot_tick, ONES→TENS and TENS→ONES.
  - One frame = 2·REFRESH_DIV cycles.
- **Shadow registers:**
  - {sh_q1, sh_q2} reset to 0.
  - Loaded from {in_q1, in_q2} only on the TENS→ONES transition (the frame boundary).
  - Inputs are ignored at all other times.
- **Blink:**
  - Frame counter runs 0..BLINK_FRAMES-1 and advances at each frame boundary.
  - On wrap, blink_phase toggles.
  - While blink_en=0, the counter and blink_phase are held at 0.
  - Reset value of both is 0.
- **Decode** (active-high codes, hex):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Codes 10–15 decode to dash = 40.
  - Inversion is applied last when SEG_ACTIVE_LOW=1.
- **Blanking priority:**
  - (blink_en & blink_phase) blanks both digits.
  - Otherwise (TENS slot & blank_lz & sh_q1==0) blanks the tens digit.
  - Otherwise the decoded value is shown.
  - Blanking = all segments off; dig keeps scanning.
- **Inputs:** no range check beyond decode; any 4-bit value is legal.

## Timing
- **Registered outputs:** seg, dig and frame_tick are all registered. seg and dig update on the same edge, so the display never shows one digit's segments on the other digit's enable.
- **Reset values** (asynchronous, while rst_n=0):
  - seg = all off (7F if SEG_ACTIVE_LOW, else 00).
  - dig = both off (11 if DIG_ACTIVE_LOW, else 00).
  - frame_tick = 0.
  - Prescaler, FSM, shadows, frame counter and blink_phase all cleared.
- **After reset release:**
  - Edge 1 drives dig = ones enabled and seg = decode(0).
  - With REFRESH_DIV=N, the FSM toggles at edges N, 2N, 3N, …; dig follows one edge later (N+1, 2N+1, …).
- **Shadow capture:** at edges 2N, 4N, ….
  - frame_tick is high for the single cycle following the capture edge.
  - The new value is first visible on the ones digit at edge 2N+1.
  - Input-to-display latency ≤ 2N+1 cycles.
- **Blink timing:**
  - blink_phase toggles at the frame boundary ending frame BLINK_FRAMES-1 and takes effect at the next output edge.
  - Deasserting blink_en clears blink_phase on the next edge; segments relight one edge after that.
- **Reset mid-frame:** all state is discarded and the first frame restarts from ONES with shadow 0.

## Test plan
Bench parameters: REFRESH_DIV=4, BLINK_FRAMES=2, both polarities active-low.
- **Reset:** hold rst_n=0 with in=23.
  - During reset: seg=7F, dig=11, frame_tick=0.
  - Edge 1 after release: dig=10, seg=40 (digit "0").
- **Normal display:** in_q1=2, in_q2=3 held from release.
  - frame_tick pulses after edge 8.
  - From edge 9: ones slot dig=10, seg=30; tens slot (edges 13–16) dig=01, seg=24.
  - dig toggles every 4 cycles.
- **Tear-free update:** change the input 09→10 at edge 13 (mid tens slot).
  - Tens keeps showing 0 (seg=40) until edge 17.
  - From edge 17, ones shows 0 (seg=40) and tens then shows 1 (seg=79).
- **Leading-zero blank:** in=05, blank_lz=1.
  - Tens slot: seg=7F with dig=01.
  - Ones slot: seg=12.
  - With blank_lz=0, the tens slot shows seg=40.
- **Invalid BCD:** in_q1=A, in_q2=F.
  - Both slots show seg=3F (dash) after the next frame boundary.
- **Blink:** blink_en=1 from reset.
  - Segments lit until edge 16; seg=7F for edges 17–32 with dig still scanning; lit again from edge 33.
  - Dropping blink_en at edge 20 relights the segments at edge 22.
